// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the mm:ss BCD timer: the run/pause/clear sequencer
//   state encoding, BCD digit limits used by the counter, and a helper that
//   sizes counters from their modulus.
// -----------------------------------------------------------------------------
package timer_pkg;

  // Sequencer states. The encoding is visible to the counter/display path,
  // so the numeric values are fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest tens-of-seconds / tens-of-minutes digit and largest units digit.
  localparam logic [3:0] BCD_SEC_MAX  = 4'h5;
  localparam logic [3:0] BCD_UNIT_MAX = 4'h9;

  // Width of a counter that runs 0..n-1. Never returns 0, so a degenerate
  // modulus of 1 still yields a legal one-bit vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Brings one raw active-low pushbutton into the clk domain, filters contact
//   bounce, and emits a single-cycle pulse when a press is accepted.
//
//   Parameters
//     DEBOUNCE_CYC  consecutive stable synchronized cycles before a new key
//                   level is accepted.
//   Ports
//     clk      in   board clock
//     reset_n  in   asynchronous reset, active-low
//     key_n    in   raw pushbutton, active-low, asynchronous to clk
//     press    out  one-cycle pulse on an accepted 1->0 transition
//
//   Timing: with the raw key falling between edges, press is high after the
//   (DEBOUNCE_CYC+2)th rising edge. Releases are filtered the same way but
//   produce no pulse.
// -----------------------------------------------------------------------------
module key_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int             DW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [DW-1:0]  CNT_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The counter only advances while the synchronized input disagrees with
  // the accepted level; any agreeing cycle restarts the stability window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  // Synchronizer and accepted level reset to "released", so a key held
  // through reset release is seen as a fresh press once it has debounced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/timer_control.sv
// -----------------------------------------------------------------------------
// timer_control
//   Run/pause/clear sequencer for the mm:ss BCD timer counter. Debounces the
//   run and clear pushbuttons, divides the board clock into a count tick, and
//   drives the counter's advance and clear strobes.
//
//   Parameters
//     CLK_HZ        clk cycles per count tick
//     DEBOUNCE_CYC  stable cycles before a key level is accepted
//     STOP_AT_MAX   1: stop in DONE at 59:59; 0: let the counter wrap
//   Ports
//     clk          in   board clock
//     reset_n      in   asynchronous reset, active-low
//     key_run_n    in   raw run/pause pushbutton, active-low
//     key_clear_n  in   raw clear pushbutton, active-low
//     cnt_at_max   in   counter currently shows 59:59
//     cnt_tick     out  one-cycle advance enable to the counter
//     cnt_clear    out  one-cycle synchronous clear to the counter
//     running      out  state is RUN
//     done         out  state is DONE
//     blink        out  HEX display enable (1 = lit)
//
//   Build option: define TIMER_CONTROL_BLINK_EN to flash the display at 1 Hz
//   while paused or done. Without it blink is constant 1 and no blink counter
//   exists.
// -----------------------------------------------------------------------------
module timer_control
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int STOP_AT_MAX  = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_run_n,
  input  logic key_clear_n,
  input  logic cnt_at_max,
  output logic cnt_tick,
  output logic cnt_clear,
  output logic running,
  output logic done,
  output logic blink
);

  localparam int            PW         = cnt_width(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam bit            STOP_EN    = (STOP_AT_MAX != 0);

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic run_press;
  logic clear_press;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_run_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_run_n),
    .press   (run_press)
  );

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_clear_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_clear_n),
    .press   (clear_press)
  );

  // ---------------------------------------------------------------------------
  // Sequencer and prescaler
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          running_q, done_q;
  logic          tick_due;

  // The prescaler advances on every edge where the registered state is RUN,
  // including the edge that leaves RUN for PAUSE. The value frozen in PAUSE
  // is therefore the phase reached at the pause edge, and resuming continues
  // exactly from there.
  assign tick_due = (state_q == RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;

    if (clear_press) begin
      // Clear beats a simultaneous run press and suppresses a due tick, which
      // also keeps cnt_tick and cnt_clear mutually exclusive.
      clear_d = 1'b1;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_press) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          presc_d = tick_due ? '0 : presc_q + PW'(1);
          if (tick_due && STOP_EN && cnt_at_max) begin
            // Hold the counter at 59:59 instead of advancing into a wrap.
            state_d = DONE;
          end else begin
            // A pause landing on a tick edge still delivers that tick.
            tick_d = tick_due;
            if (run_press) begin
              state_d = PAUSE;
            end
          end
        end
        PAUSE: begin
          if (run_press) begin
            state_d = RUN;
          end
        end
        DONE: begin
          // Only clear leaves DONE.
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign cnt_tick  = tick_q;
  assign cnt_clear = clear_q;
  assign running   = running_q;
  assign done      = done_q;

  // ---------------------------------------------------------------------------
  // Display blink
  // ---------------------------------------------------------------------------
`ifdef TIMER_CONTROL_BLINK_EN
  localparam int            BLINK_HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int            BW         = cnt_width(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          hold_next;

  assign hold_next = (state_d == PAUSE) || (state_d == DONE);

  // Entering PAUSE/DONE restarts the half-period with the display lit, so the
  // first dark phase always begins a full half-second after the stop.
  always_comb begin
    blink_d = 1'b1;
    bcnt_d  = '0;
    if (hold_next) begin
      if (state_d != state_q) begin
        blink_d = 1'b1;
        bcnt_d  = '0;
      end else if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_timer_control.sv
module tb_timer_control;

  localparam int CLK_HZ       = 8;
  localparam int DEBOUNCE_CYC = 4;

`ifdef TIMER_CONTROL_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic key_run_n;
  logic key_clear_n;
  logic cnt_at_max;
  logic cnt_tick;
  logic cnt_clear;
  logic running;
  logic done;
  logic blink;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboards: cycle numbers at which a tick / clear pulse is expected.
  int exp_tick[$];
  int exp_clr[$];

  timer_control #(
    .CLK_HZ       (CLK_HZ),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .STOP_AT_MAX  (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_run_n   (key_run_n),
    .key_clear_n (key_clear_n),
    .cnt_at_max  (cnt_at_max),
    .cnt_tick    (cnt_tick),
    .cnt_clear   (cnt_clear),
    .running     (running),
    .done        (done),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Output monitor: pops the scoreboards whenever a strobe is seen.
  always @(negedge clk) begin
    if (cnt_tick) begin
      if (exp_tick.size() == 0) check("tick_unexpected", cnt_tick, 1'b0);
      else                      check("tick_cycle", cyc, exp_tick.pop_front());
    end
    if (cnt_clear) begin
      if (exp_clr.size() == 0) check("clear_unexpected", cnt_clear, 1'b0);
      else                     check("clear_cycle", cyc, exp_clr.pop_front());
    end
    if (cnt_tick && cnt_clear) check("tick_clear_excl", {cnt_tick, cnt_clear}, 2'b00);
  end

  initial begin
    int t0, c_run, y, z, w;
    logic seen;

    reset_n     = 1'b1;
    key_run_n   = 1'b1;
    key_clear_n = 1'b1;
    cnt_at_max  = 1'b0;

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    check("rst_tick", cnt_tick, 1'b0);
    check("rst_clear", cnt_clear, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_blink", blink, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1a: a 3-cycle glitch must be rejected
    key_run_n = 1'b0;
    repeat (3) @(negedge clk);
    key_run_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | running;
    end
    check("t1_glitch_no_run", seen, 1'b0);

    // 1b: a 12-cycle press starts RUN on edge 7 after the fall
    t0 = cyc;
    key_run_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("t1_run_edge", running, (k >= 7));
    end
    key_run_n = 1'b1;
    c_run = t0 + 7;

    // 2: five ticks, 8 cycles apart, first 8 cycles after running rises
    for (int i = 1; i <= 5; i++) exp_tick.push_back(c_run + 8 * i);

    // 3: pause lands 5 cycles after the tick at +40, resume at +70
    wait_cyc(c_run + 38);
    key_run_n = 1'b0;
    wait_cyc(c_run + 44);
    check("t3_run_before_pause", running, 1'b1);
    check("t3_blink_in_run", blink, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check("t3_paused", running, 1'b0);
      check("t3_blink_pause", blink, BLINK_EN ? (k < 4) : 1'b1);
    end
    wait_cyc(c_run + 50);
    key_run_n = 1'b1;
    wait_cyc(c_run + 63);
    key_run_n = 1'b0;
    exp_tick.push_back(c_run + 73);
    exp_tick.push_back(c_run + 81);
    wait_cyc(c_run + 69);
    check("t3_still_paused", running, 1'b0);
    @(negedge clk);
    check("t3_resumed", running, 1'b1);
    check("t3_blink_resumed", blink, 1'b1);
    wait_cyc(c_run + 70);
    key_run_n = 1'b1;

    // 4: run + clear together during RUN: clear wins
    wait_cyc(c_run + 80);
    key_run_n   = 1'b0;
    key_clear_n = 1'b0;
    exp_clr.push_back(c_run + 87);
    wait_cyc(c_run + 86);
    check("t4_running_before", running, 1'b1);
    @(negedge clk);
    check("t4_idle_running", running, 1'b0);
    check("t4_idle_done", done, 1'b0);
    wait_cyc(c_run + 92);
    key_run_n   = 1'b1;
    key_clear_n = 1'b1;
    wait_cyc(c_run + 110);
    check("t4_no_more_ticks", exp_tick.size(), 0);
    check("t4_still_idle", running, 1'b0);

    // 5: stop at 59:59, run ignored in DONE, clear exits
    cnt_at_max = 1'b1;
    y = cyc;
    key_run_n = 1'b0;
    wait_cyc(y + 7);
    check("t5_run", running, 1'b1);
    key_run_n = 1'b1;
    wait_cyc(y + 14);
    check("t5_pre_done", done, 1'b0);
    @(negedge clk);
    check("t5_done", done, 1'b1);
    check("t5_done_running", running, 1'b0);
    wait_cyc(y + 19);
    check("t5_blink_done", blink, BLINK_EN ? 1'b0 : 1'b1);
    wait_cyc(y + 20);
    key_run_n = 1'b0;
    wait_cyc(y + 28);
    check("t5_run_ignored_done", done, 1'b1);
    check("t5_run_ignored_running", running, 1'b0);
    key_run_n = 1'b1;
    wait_cyc(y + 34);
    key_clear_n = 1'b0;
    exp_clr.push_back(y + 41);
    wait_cyc(y + 41);
    check("t5_cleared_done", done, 1'b0);
    check("t5_cleared_running", running, 1'b0);
    check("t5_cleared_blink", blink, 1'b1);
    wait_cyc(y + 42);
    key_clear_n = 1'b1;
    cnt_at_max  = 1'b0;

    // 6: asynchronous reset mid-RUN, on the cycle a tick is being issued
    wait_cyc(y + 60);
    z = cyc;
    key_run_n = 1'b0;
    wait_cyc(z + 8);
    key_run_n = 1'b1;
    wait_cyc(z + 14);
    check("t6_running", running, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_tick", cnt_tick, 1'b0);
    check("t6_rst_clear", cnt_clear, 1'b0);
    check("t6_rst_running", running, 1'b0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_blink", blink, 1'b1);

    // 7: key held through reset release is taken as a press
    key_run_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    w = cyc;
    exp_tick.push_back(w + 15);
    wait_cyc(w + 6);
    check("t7_not_yet", running, 1'b0);
    @(negedge clk);
    check("t7_running", running, 1'b1);
    wait_cyc(w + 8);
    key_run_n = 1'b1;
    wait_cyc(w + 20);

    check("end_tick_queue", exp_tick.size(), 0);
    check("end_clear_queue", exp_clr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
